// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller for a 64x8 dual-port RAM (port 1 writes, port 2 reads)
// Ports:
//   clk, rst_n (async active-low), flush (sync clear)
//   wr_en/wr_data push side; rd_en pop side; rd_data/rd_valid popped word, 1-cycle latency
//   full/empty/almost_full/almost_empty/count occupancy status; overflow/underflow sticky errors
//   ram_*_1 write port drive; ram_*_2 read port drive; ram_q_2 registered RAM read data
module dpram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_wen_1,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [DATA_W-1:0] ram_data_1,
  output logic              ram_wen_2,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic [DATA_W-1:0] ram_data_2,
  input  logic [DATA_W-1:0] ram_q_2
);
  localparam logic [ADDR_W:0] AF = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE = AE_THRESH[ADDR_W:0];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              push_ok, pop_ok;
  // count tops out at exactly DEPTH, so its MSB alone marks full
  assign full         = count_q[ADDR_W];
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF;
  assign almost_empty = count_q <= AE;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign rd_valid     = valid_q;
  assign push_ok      = wr_en & ~full & ~flush;
  assign pop_ok       = rd_en & ~empty & ~flush;
  // RAM output is live only in the cycle after a pop; otherwise show the last popped word
  assign rd_data      = valid_q ? ram_q_2 : hold_q;
  assign ram_wen_1    = push_ok;
  assign ram_addr_1   = wptr_q;
  assign ram_data_1   = wr_data;
  assign ram_wen_2    = 1'b0;
  assign ram_addr_2   = rptr_q;
  assign ram_data_2   = '0;
  always_comb begin
    wptr_d  = flush ? '0 : wptr_q + ADDR_W'(push_ok);
    rptr_d  = flush ? '0 : rptr_q + ADDR_W'(pop_ok);
    count_d = flush ? '0 : count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    ovf_d   = ~flush & (ovf_q | (wr_en & full));
    udf_d   = ~flush & (udf_q | (rd_en & empty));
    valid_d = pop_ok;
    hold_d  = valid_q ? ram_q_2 : hold_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: self-checking bench with a queue-based reference model and a behavioural 64x8 RAM
module tb_dpram_fifo_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0, rd_data, ram_data_1, ram_data_2, ram_q_2;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic       ram_wen_1, ram_wen_2;
  logic [6:0] count;
  logic [5:0] ram_addr_1, ram_addr_2;
  logic [7:0] mem [64];
  int checks = 0, errors = 0;

  logic [7:0] mq[$];
  int         m_wp, m_rp;
  bit         m_ovf, m_udf, m_valid;
  logic [7:0] m_last;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen_1) mem[ram_addr_1] <= ram_data_1;
    ram_q_2 <= mem[ram_addr_2];
  end

  dpram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_wen_1(ram_wen_1),
    .ram_addr_1(ram_addr_1), .ram_data_1(ram_data_1), .ram_wen_2(ram_wen_2),
    .ram_addr_2(ram_addr_2), .ram_data_2(ram_data_2), .ram_q_2(ram_q_2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_last = '0;
  endfunction

  function automatic void model_step(input logic w, input logic [7:0] d, input logic r, input logic f);
    bit was_full, was_empty;
    was_full = mq.size() == 64;
    was_empty = mq.size() == 0;
    m_valid = 0;
    if (f) begin
      mq.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (w && was_full) m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      if (r && !was_empty) begin
        m_last = mq.pop_front(); m_rp = (m_rp + 1) % 64; m_valid = 1;
      end
      if (w && !was_full) begin
        mq.push_back(d); m_wp = (m_wp + 1) % 64;
      end
    end
  endfunction

  task automatic check_state();
    int n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 64));
    chk("almost_full", 32'(almost_full), 32'(n >= 56));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 8));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_last));
    chk("ram_addr_1", 32'(ram_addr_1), 32'(m_wp));
    chk("ram_addr_2", 32'(ram_addr_2), 32'(m_rp));
    chk("ram_port2_tied", {ram_wen_2, ram_data_2}, 0);
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    #1;
    chk("ram_wen_1", 32'(ram_wen_1), 32'(w && mq.size() < 64 && !f));
    chk("ram_data_1", 32'(ram_data_1), 32'(d));
    @(posedge clk);
    model_step(w, d, r, f);
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0;
    check_state();
  endtask

  typedef struct {
    logic w; logic [7:0] d; logic r; logic f;
    int cnt; logic v; logic [7:0] dat;
  } vec_t;
  vec_t vt[7];

  initial begin
    int pushed;
    vt[0] = '{1, 8'h11, 0, 0, 1, 0, 8'h00};
    vt[1] = '{1, 8'h22, 0, 0, 2, 0, 8'h00};
    vt[2] = '{1, 8'h33, 0, 0, 3, 0, 8'h00};
    vt[3] = '{0, 8'h00, 1, 0, 2, 1, 8'h11};
    vt[4] = '{0, 8'h00, 1, 0, 1, 1, 8'h22};
    vt[5] = '{0, 8'h00, 1, 0, 0, 1, 8'h33};
    vt[6] = '{0, 8'h00, 0, 0, 0, 0, 8'h33};
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;
    @(negedge clk);

    // push three, pop three
    foreach (vt[i]) begin
      cycle(vt[i].w, vt[i].d, vt[i].r, vt[i].f);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vt[i].dat));
    end
    chk("t1_empty", 32'(empty), 1);

    // fill to full, overflow, drain
    for (int i = 0; i < 64; i++) begin
      cycle(1, 8'(i), 0, 0);
      chk("t2_af_edge", 32'(almost_full), 32'(i + 1 >= 56));
    end
    chk("t2_full", 32'(full), 1);
    cycle(1, 8'hAA, 0, 0);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_count64", 32'(count), 64);
    for (int i = 0; i < 64; i++) begin
      cycle(0, 0, 1, 0);
      chk("t2_order", 32'(rd_data), 32'(i));
    end
    cycle(0, 0, 0, 1);

    // random push/pop with gaps through pointer wrap
    pushed = 0;
    for (int i = 0; i < 3000 && (pushed < 100 || mq.size() > 0); i++) begin
      logic w, r;
      w = pushed < 100 && $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 2) != 0;
      if (w && mq.size() < 64) pushed++;
      cycle(w, 8'($urandom), r, 0);
    end
    chk("t3_done", 32'(pushed == 100 && mq.size() == 0), 1);
    cycle(0, 0, 0, 1);

    // simultaneous push and pop at count 10, then underflow
    for (int i = 0; i < 10; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    cycle(1, 8'h77, 1, 0);
    chk("t4_count10", 32'(count), 10);
    chk("t4_valid", 32'(rd_valid), 1);
    chk("t4_data", 32'(rd_data), 32'h40);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("t4_underflow", 32'(underflow), 1);
    chk("t4_no_valid", 32'(rd_valid), 0);

    // flush with a pending pop at count 20
    for (int i = 0; i < 20; i++) cycle(1, 8'(i * 3), 0, 0);
    cycle(1, 8'hEE, 1, 1);
    chk("t5_count0", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_no_valid", 32'(rd_valid), 0);
    chk("t5_flags", {30'd0, overflow, underflow}, 0);
    cycle(1, 8'h5A, 0, 0);
    cycle(0, 0, 1, 0);
    chk("t5_data", 32'(rd_data), 32'h5A);

    // asynchronous reset between edges with a pop in flight
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
    cycle(0, 0, 1, 0);
    chk("t6_pre_valid", 32'(rd_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    check_state();
    cycle(1, 8'h9C, 0, 0);
    cycle(0, 0, 1, 0);
    chk("t6_after", 32'(rd_data), 32'h9C);
    cycle(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
